nt_subckt_stim_driver: RTL and testbench

// Drive end of the Nt-node subcircuit test harness: produces pseudo-random 9-bit input vectors
// for a DUT subcircuit (9 in / 1 out, one flop stage deep).

---
 rtl/nt_stim_pkg.sv | 22 ++
 rtl/nt_misr.sv | 34 +++
 rtl/nt_subckt_stim_driver.sv | 142 ++++++++++++++
 tb/tb_nt_subckt_stim_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nt_stim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nt_stim_pkg                                                       |
// | Brief  : Shared types and constants for the Nt subcircuit stimulus driver. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package nt_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_lfsr_poly = 16'hB400;
    localparam logic [15:0] c_misr_poly = 16'h1021;
    // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
    localparam int          c_seed_sub  = 1;

endpackage
`default_nettype wire

// File: rtl/nt_misr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nt_misr                                                           |
// | Brief  : Left-shifting single-input signature register for response data.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module nt_misr
    import nt_stim_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = c_misr_poly
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= (r_sig << 1) ^ (r_sig[MISR_W-1] ? MISR_POLY : '0) ^ MISR_W'(din);
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/nt_subckt_stim_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nt_subckt_stim_driver                                             |
// | Brief  : LFSR pattern source and MISR response compactor for a subcircuit. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module nt_subckt_stim_driver
    import nt_stim_pkg::*;
#(
    parameter int                N_IN      = 9,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = c_lfsr_poly,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = c_misr_poly,
    parameter int                CNT_W     = 10,
    parameter int                RESP_LAT  = 1
) (
    input  logic              I1470,
    input  logic              I1477,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  pat_count,
    output logic [N_IN-1:0]   stim_out,
    output logic              stim_valid,
    input  logic              resp_in,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
);

    localparam int               DW          = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [DW-1:0]    c_drain_one = DW'(1);

    state_t              r_state;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_remaining;
    logic [DW-1:0]       r_drain;
    logic [RESP_LAT-1:0] r_pipe;
    logic [N_IN-1:0]     r_stim_out;
    logic                r_stim_valid;
    logic                r_busy;
    logic                r_done;

    logic [LFSR_W-1:0]   w_seed;
    logic                w_accept;

    function automatic logic [LFSR_W-1:0] f_lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction

    assign w_seed   = (seed == '0) ? LFSR_W'(c_seed_sub) : seed;
    assign w_accept = (r_state == IDLE) && start;

    // r_lfsr always holds the vector to be issued next; the first vector is
    // taken straight from the seed so stim_out can stay registered.
    always_ff @(posedge I1470) begin
        if (I1477) begin
            r_state      <= IDLE;
            r_lfsr       <= LFSR_W'(c_seed_sub);
            r_remaining  <= '0;
            r_drain      <= '0;
            r_stim_out   <= '0;
            r_stim_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (pat_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= DRIVE;
                            r_stim_valid <= 1'b1;
                            r_stim_out   <= w_seed[N_IN-1:0];
                            r_lfsr       <= f_lfsr_step(w_seed);
                            r_remaining  <= pat_count - c_cnt_one;
                        end
                    end
                end
                DRIVE: begin
                    if (r_remaining != '0) begin
                        r_stim_out  <= r_lfsr[N_IN-1:0];
                        r_lfsr      <= f_lfsr_step(r_lfsr);
                        r_remaining <= r_remaining - c_cnt_one;
                    end else begin
                        r_stim_valid <= 1'b0;
                        r_stim_out   <= '0;
                        r_drain      <= DW'(RESP_LAT - 1);
                        r_state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait out the response latency of the final vector.
                    if (r_drain == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - c_drain_one;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Oldest bit marks the cycle whose resp_in belongs to a driven vector.
    always_ff @(posedge I1470) begin
        if (I1477) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= RESP_LAT'({r_pipe, r_stim_valid});
        end
    end

    nt_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk (I1470),
        .rst (I1477),
        .clr (w_accept),
        .en  (r_pipe[RESP_LAT-1]),
        .din (resp_in),
        .sig (signature)
    );

    assign stim_out   = r_stim_out;
    assign stim_valid = r_stim_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nt_subckt_stim_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_nt_subckt_stim_driver                                          |
// | Brief  : Table-driven self-checking bench, RESP_LAT=1 and RESP_LAT=3 DUTs. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_nt_subckt_stim_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [9:0]  pat_count;
    logic        resp_in;

    logic [8:0]  so_a, so_b;
    logic        sv_a, sv_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] sig_a, sig_b;

    always #5 clk = ~clk;

    nt_subckt_stim_driver u_dut_a (
        .I1470      (clk),
        .I1477      (rst),
        .start      (start),
        .seed       (seed),
        .pat_count  (pat_count),
        .stim_out   (so_a),
        .stim_valid (sv_a),
        .resp_in    (resp_in),
        .busy       (busy_a),
        .done       (done_a),
        .signature  (sig_a)
    );

    nt_subckt_stim_driver #(.RESP_LAT(3)) u_dut_b (
        .I1470      (clk),
        .I1477      (rst),
        .start      (start),
        .seed       (seed),
        .pat_count  (pat_count),
        .stim_out   (so_b),
        .stim_valid (sv_b),
        .resp_in    (resp_in),
        .busy       (busy_b),
        .done       (done_b),
        .signature  (sig_b)
    );

    typedef struct {
        logic [15:0] seed;
        int          cnt;
        bit          lat3;
        int          rmode;      // 0: resp 0, 1: resp 1, 2: random
        bit          restart;
        bit          sig_known;
        logic [15:0] exp_sig;
        logic [8:0]  exp_first;
    } vec_t;

    int         nvec = 0;
    int         nbad = 0;
    logic [8:0] exp_q[$];
    vec_t       tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, d};
    endfunction

    task automatic run(input vec_t v);
        int          lat;
        int          n;
        int          done_cyc;
        logic [15:0] m;
        logic [15:0] sig_e;
        logic        r;
        logic [8:0]  so;
        logic        sv, bs, dn;
        logic [15:0] sg;
        lat      = v.lat3 ? 3 : 1;
        n        = v.cnt;
        done_cyc = (n == 0) ? 1 : n + lat + 1;
        sig_e    = 16'h0000;
        exp_q.delete();
        m = (v.seed == 16'h0000) ? 16'h0001 : v.seed;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m[8:0]);
            m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge clk); #1;
        start     = 1'b1;
        seed      = v.seed;
        pat_count = 10'(n);
        resp_in   = 1'b0;
        for (int c = 1; c <= done_cyc + 3; c++) begin
            @(posedge clk); #1;
            start     = v.restart && (c == 2);
            seed      = 16'h5A5A;
            pat_count = 10'd7;
            case (v.rmode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            resp_in = r;
            if (c >= 1 + lat && c <= n + lat) sig_e = misr_step(sig_e, r);
            @(negedge clk);
            so = v.lat3 ? so_b   : so_a;
            sv = v.lat3 ? sv_b   : sv_a;
            bs = v.lat3 ? busy_b : busy_a;
            dn = v.lat3 ? done_b : done_a;
            sg = v.lat3 ? sig_b  : sig_a;
            chk("stim_valid", 32'(sv), 32'(c <= n));
            if (sv) begin
                if (exp_q.size() == 0) chk("extra_vector", 32'(sv), 32'd0);
                else                   chk("stim_out", 32'(so), 32'(exp_q.pop_front()));
            end
            if (c == 1 && n > 0) chk("first_vector", 32'(so), 32'(v.exp_first));
            chk("busy", 32'(bs), 32'(c <= done_cyc));
            chk("done", 32'(dn), 32'(c == done_cyc));
            if (c == done_cyc) begin
                chk("signature", 32'(sg), 32'(sig_e));
                if (v.sig_known) chk("signature_const", 32'(sg), 32'(v.exp_sig));
            end
            if (c == done_cyc + 3) chk("signature_hold", 32'(sg), 32'(sig_e));
        end
        chk("vectors_left", 32'(exp_q.size()), 32'd0);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        seed      = 16'h0000;
        pat_count = 10'd0;
        resp_in   = 1'b0;

        tbl[0] = '{16'h0001,  2, 1'b0, 2, 1'b0, 1'b0, 16'h0000, 9'h001};
        tbl[1] = '{16'h0000,  1, 1'b0, 2, 1'b0, 1'b0, 16'h0000, 9'h001};
        tbl[2] = '{16'h1234,  3, 1'b0, 1, 1'b0, 1'b1, 16'h0007, 9'h034};
        tbl[3] = '{16'h4321,  0, 1'b0, 1, 1'b0, 1'b1, 16'h0000, 9'h000};
        tbl[4] = '{16'hBEEF,  4, 1'b1, 2, 1'b1, 1'b0, 16'h0000, 9'h0EF};
        tbl[5] = '{16'hACE1, 25, 1'b0, 2, 1'b0, 1'b0, 16'h0000, 9'h0E1};
        tbl[6] = '{16'h8000,  6, 1'b1, 1, 1'b0, 1'b0, 16'h0000, 9'h000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",  32'(busy_a), 32'd0);
        chk("reset_valid", 32'(sv_a),   32'd0);
        chk("reset_done",  32'(done_a), 32'd0);
        chk("reset_sig",   32'(sig_a),  32'd0);
        chk("reset_out",   32'(so_a),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Reset held for three cycles mid-DRIVE, with a start colliding with it.
        @(posedge clk); #1;
        start     = 1'b1;
        seed      = 16'hACE1;
        pat_count = 10'd20;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start   = (c == 5);
            rst     = (c >= 4) && (c <= 6);
            resp_in = 1'b1;
            @(negedge clk);
            if (c < 4) begin
                chk("pre_reset_busy",  32'(busy_a), 32'd1);
                chk("pre_reset_valid", 32'(sv_a),   32'd1);
            end else if (c >= 5) begin
                chk("abort_busy_a",  32'(busy_a), 32'd0);
                chk("abort_busy_b",  32'(busy_b), 32'd0);
                chk("abort_valid_a", 32'(sv_a),   32'd0);
                chk("abort_valid_b", 32'(sv_b),   32'd0);
                chk("abort_done_a",  32'(done_a), 32'd0);
                chk("abort_done_b",  32'(done_b), 32'd0);
                chk("abort_sig_a",   32'(sig_a),  32'd0);
                chk("abort_sig_b",   32'(sig_b),  32'd0);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
`default_nettype wire
